// File: rtl/seg_readback_decoder.sv
// seg_readback_decoder: snapshots DIGITS active-low 7-seg patterns and rebuilds the packed hex value, one digit per clock.
//   clk     system clock
//   resetn  synchronous active-low reset
//   start   begin a readback (IDLE only)
//   seg_in  digit k at [7k+6:7k], bit 6 = seg g, active-low
//   ack     consumer accepts result (DONE only)
//   value   decoded nibbles, digit k at [4k+3:4k]
//   valid   result held until ack
//   error   some digit held an illegal pattern
//   err_idx lowest illegal digit index
//   busy    high in DECODE and DONE
module seg_readback_decoder #(
    parameter int DIGITS   = 6,
    parameter bit BLANK_OK = 1'b0
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [7*DIGITS-1:0]   seg_in,
    input  logic                  ack,
    output logic [4*DIGITS-1:0]   value,
    output logic                  valid,
    output logic                  error,
    output logic [2:0]            err_idx,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, DECODE, DONE} state_t;

    state_t                state, state_n;
    logic [7*DIGITS-1:0]   snap;
    logic [2:0]            idx;
    logic [4:0]            d;
    logic                  last;

    // {illegal, nibble}
    function automatic logic [4:0] dec(input logic [6:0] p);
        case (p)
            7'h40: dec = 5'h00;
            7'h79: dec = 5'h01;
            7'h24: dec = 5'h02;
            7'h30: dec = 5'h03;
            7'h19: dec = 5'h04;
            7'h12: dec = 5'h05;
            7'h02: dec = 5'h06;
            7'h78: dec = 5'h07;
            7'h00: dec = 5'h08;
            7'h18: dec = 5'h09;
            7'h08: dec = 5'h0A;
            7'h03: dec = 5'h0B;
            7'h46: dec = 5'h0C;
            7'h21: dec = 5'h0D;
            7'h06: dec = 5'h0E;
            7'h0E: dec = 5'h0F;
            7'h7F: dec = BLANK_OK ? 5'h00 : 5'h10;
            default: dec = 5'h10;
        endcase
    endfunction

    assign d     = dec(snap[7*int'(idx) +: 7]);
    assign last  = idx == 3'(DIGITS-1);
    assign valid = state == DONE;
    assign busy  = state != IDLE;

    always_comb begin
        state_n = (state == IDLE   && start) ? DECODE :
                  (state == DECODE && last)  ? DONE   :
                  (state == DONE   && ack)   ? IDLE   : state;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= IDLE;
            snap    <= '0;
            idx     <= '0;
            value   <= '0;
            error   <= 1'b0;
            err_idx <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && start) begin
                snap    <= seg_in;
                idx     <= '0;
                value   <= '0;
                error   <= 1'b0;
                err_idx <= '0;
            end else if (state == DECODE) begin
                value[4*int'(idx) +: 4] <= d[3:0];
                // first illegal digit wins
                if (d[4] && !error)
                    err_idx <= idx;
                error <= error | d[4];
                idx   <= idx + 3'd1;
            end
        end
    end
endmodule
